// File: rtl/mux_reg_dest.sv
// Execute-stage destination-register selector with EX/MEM and MEM/WB
// destination tracking and per-stage source-match flags for hazard logic.

module mux_reg_dest_hit #(
  parameter int unsigned AW     = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic [AW-1:0]             src,
  input  logic [STAGES-1:0][AW-1:0] dst,
  input  logic [STAGES-1:0]         wen,
  output logic [STAGES-1:0]         hit
);
  // r0 is hardwired zero, so a zero source never needs forwarding
  always_comb begin
    hit = '0;
    for (int s = 0; s < STAGES; s++)
      hit[s] = wen[s] & (dst[s] == src) & (src != '0);
  end
endmodule

module mux_reg_dest #(
  parameter int unsigned AW       = 5,
  parameter int unsigned LINK_REG = 31
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rt,
  input  logic [AW-1:0] rd,
  input  logic          reg_dest,
  input  logic          link,
  input  logic          reg_write,
  input  logic          stall,
  input  logic          flush,
  input  logic [AW-1:0] rs_src,
  input  logic [AW-1:0] rt_src,
  output logic [AW-1:0] rw,
  output logic          wr_en,
  output logic [AW-1:0] rw_mem,
  output logic          wr_en_mem,
  output logic [AW-1:0] rw_wb,
  output logic          wr_en_wb,
  output logic [1:0]    hit_rs,
  output logic [1:0]    hit_rt
);
  localparam int unsigned NSRC   = 2;
  localparam int unsigned STAGES = 2;

  typedef struct packed {
    logic [AW-1:0] rw;
    logic          en;
  } dst_t;

  dst_t mem_q, mem_d, wb_q, wb_d;
  dst_t ex;

  assign rw    = link ? AW'(LINK_REG) : (reg_dest ? rd : rt);
  assign wr_en = reg_write & (rw != '0);
  assign ex    = '{rw: rw, en: wr_en};

  // flush beats stall in EX/MEM; WB bubbles only on a pure stall,
  // so a flushed cycle still retires the older MEM instruction
  always_comb begin
    mem_d = mem_q;
    if (flush)       mem_d = '0;
    else if (!stall) mem_d = ex;
    wb_d = (stall && !flush) ? dst_t'('0) : mem_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign rw_mem    = mem_q.rw;
  assign wr_en_mem = mem_q.en;
  assign rw_wb     = wb_q.rw;
  assign wr_en_wb  = wb_q.en;

  // stage index 1 = MEM, 0 = WB; source index 0 = rs, 1 = rt
  logic [NSRC-1:0][AW-1:0]     src;
  logic [STAGES-1:0][AW-1:0]   dst;
  logic [STAGES-1:0]           wen;
  logic [NSRC-1:0][STAGES-1:0] hit;

  assign src = {rt_src, rs_src};
  assign dst = {mem_q.rw, wb_q.rw};
  assign wen = {mem_q.en, wb_q.en};

  for (genvar g = 0; g < NSRC; g++) begin : g_hit
    mux_reg_dest_hit #(.AW(AW), .STAGES(STAGES)) u_hit (
      .src (src[g]),
      .dst (dst),
      .wen (wen),
      .hit (hit[g])
    );
  end

  assign hit_rs = hit[0];
  assign hit_rt = hit[1];
endmodule

// File: tb/tb_mux_reg_dest.sv
// Directed plus randomized check of mux_reg_dest against a pipeline model.

module tb_mux_reg_dest;
  localparam int AW = 5;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] rt = '0, rd = '0, rs_src = '0, rt_src = '0;
  logic          reg_dest = 0, link = 0, reg_write = 0, stall = 0, flush = 0;
  logic [AW-1:0] rw, rw_mem, rw_wb;
  logic          wr_en, wr_en_mem, wr_en_wb;
  logic [1:0]    hit_rs, hit_rt;

  int checks = 0, errors = 0;

  // model: one entry per in-flight stage
  int m_mem_rw = 0, m_wb_rw = 0;
  bit m_mem_en = 0, m_wb_en = 0;

  mux_reg_dest #(.AW(AW), .LINK_REG(31)) dut (
    .clk(clk), .rst_n(rst_n), .rt(rt), .rd(rd), .reg_dest(reg_dest),
    .link(link), .reg_write(reg_write), .stall(stall), .flush(flush),
    .rs_src(rs_src), .rt_src(rt_src), .rw(rw), .wr_en(wr_en),
    .rw_mem(rw_mem), .wr_en_mem(wr_en_mem), .rw_wb(rw_wb),
    .wr_en_wb(wr_en_wb), .hit_rs(hit_rs), .hit_rt(hit_rt)
  );

  always #5 clk = ~clk;

  function automatic int exp_rw();
    if (link) return 31;
    return reg_dest ? int'(rd) : int'(rt);
  endfunction

  function automatic bit exp_en();
    return reg_write && exp_rw() != 0;
  endfunction

  function automatic int exp_hit(int s);
    int h = 0;
    if (s != 0 && m_mem_en && m_mem_rw == s) h += 2;
    if (s != 0 && m_wb_en  && m_wb_rw  == s) h += 1;
    return h;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rw"},        32'(rw),        exp_rw());
    chk({tag, ".wr_en"},     32'(wr_en),     32'(exp_en()));
    chk({tag, ".rw_mem"},    32'(rw_mem),    m_mem_rw);
    chk({tag, ".wr_en_mem"}, 32'(wr_en_mem), 32'(m_mem_en));
    chk({tag, ".rw_wb"},     32'(rw_wb),     m_wb_rw);
    chk({tag, ".wr_en_wb"},  32'(wr_en_wb),  32'(m_wb_en));
    chk({tag, ".hit_rs"},    32'(hit_rs),    exp_hit(int'(rs_src)));
    chk({tag, ".hit_rt"},    32'(hit_rt),    exp_hit(int'(rt_src)));
  endtask

  // advance one edge; the model computes next state from the inputs seen at the edge
  task automatic clock();
    int n_mem_rw = m_mem_rw, n_wb_rw;
    bit n_mem_en = m_mem_en, n_wb_en;
    if (flush) begin
      n_mem_rw = 0; n_mem_en = 0;
    end else if (!stall) begin
      n_mem_rw = exp_rw(); n_mem_en = exp_en();
    end
    if (stall && !flush) begin
      n_wb_rw = 0; n_wb_en = 0;
    end else begin
      n_wb_rw = m_mem_rw; n_wb_en = m_mem_en;
    end
    @(posedge clk);
    if (rst_n) begin
      m_mem_rw = n_mem_rw; m_mem_en = n_mem_en;
      m_wb_rw  = n_wb_rw;  m_wb_en  = n_wb_en;
    end
    #1;
  endtask

  task automatic instr(input int t, input int d, input bit rdst, input bit lnk, input bit wr);
    rt = AW'(t); rd = AW'(d); reg_dest = rdst; link = lnk; reg_write = wr;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // select is combinational: no edge between the two checks
    instr(5'h1F, 5'h0F, 1, 0, 1); #1;
    chk("sel_rd", 32'(rw), 32'h0F);
    reg_dest = 0; #1;
    chk("sel_rt", 32'(rw), 32'h1F);

    instr(3, 4, 0, 1, 1); #1;
    chk("link0.rw", 32'(rw), 31); chk("link0.en", 32'(wr_en), 1);
    reg_dest = 1; #1;
    chk("link1.rw", 32'(rw), 31); chk("link1.en", 32'(wr_en), 1);
    instr(0, 9, 0, 0, 1); #1;
    chk("r0.en", 32'(wr_en), 0);

    // pipeline sequence with rs_src tracking r5
    instr(0, 5, 1, 0, 1); rs_src = 5; rt_src = 7;
    clock();
    chk("pipe1.rw_mem", 32'(rw_mem), 5); chk("pipe1.en_mem", 32'(wr_en_mem), 1);
    chk("pipe1.hit_rs", 32'(hit_rs), 2'b10);
    reg_write = 0;
    clock();
    chk("pipe2.rw_wb", 32'(rw_wb), 5); chk("pipe2.en_wb", 32'(wr_en_wb), 1);
    chk("pipe2.hit_rs", 32'(hit_rs), 2'b01);
    check_all("pipe2");

    // stall holds MEM and bubbles WB; stall+flush kills MEM, retires old MEM
    instr(0, 9, 1, 0, 1); rs_src = 9;
    clock();
    instr(0, 12, 1, 0, 1); stall = 1;
    clock();
    chk("stall.rw_mem", 32'(rw_mem), 9); chk("stall.rw_wb", 32'(rw_wb), 0);
    chk("stall.en_wb", 32'(wr_en_wb), 0);
    check_all("stall");
    flush = 1;
    clock();
    chk("sf.en_mem", 32'(wr_en_mem), 0); chk("sf.rw_wb", 32'(rw_wb), 9);
    chk("sf.en_wb", 32'(wr_en_wb), 1);
    check_all("stall_flush");
    stall = 0; flush = 0;

    // zero-register sources never match
    instr(0, 3, 1, 0, 1); rs_src = 0; rt_src = 0;
    clock(); clock();
    chk("zero.hit_rs", 32'(hit_rs), 0); chk("zero.hit_rt", 32'(hit_rt), 0);
    instr(0, 0, 0, 0, 1);
    clock();
    check_all("zero");

    // mid-cycle asynchronous reset with live pipeline state
    instr(0, 6, 1, 0, 1);
    clock(); clock();
    #2 rst_n = 0; #1;
    m_mem_rw = 0; m_mem_en = 0; m_wb_rw = 0; m_wb_en = 0;
    chk("async.rw_mem", 32'(rw_mem), 0); chk("async.en_wb", 32'(wr_en_wb), 0);
    check_all("async_rst");
    clock();
    rst_n = 1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      instr($urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
      stall  = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 7) == 0);
      rs_src = AW'($urandom_range(0, 31));
      rt_src = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) begin
        rs_src = AW'(m_mem_rw);
        rt_src = AW'(m_wb_rw);
      end
      #1;
      check_all("rnd_comb");
      clock();
      check_all("rnd_seq");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
